// File: rtl/lz4_block_scheduler.sv
// Round-robin scheduler sharing one LZ4 decompressor between two length-prefixed block sources.
// Optional requester stall watchdog is enabled by defining LZ4_SCHED_TIMEOUT_EN.
module lz4_block_scheduler #(
  parameter int word_size      = 8,
  parameter int len_width      = 16,
  parameter int timeout_cycles = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  input  logic [2*word_size-1:0] req_word,
  output logic [1:0]             req_ready,
  input  logic                   dec_ready,
  output logic [word_size-1:0]   compressed_word,
  output logic                   write,
  output logic                   active_src,
  output logic                   busy,
  output logic                   block_done,
  output logic                   timeout_err
);
  // Handshake: a byte moves on requester n exactly when req_valid[n] & req_ready[n]
  // at a rising edge; valid never waits for ready and ready never waits for valid.

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, STREAM, DONE} state_t;

  state_t               state;
  logic                 ptr;
  logic [word_size-1:0] len_lo;
  logic [len_width-1:0] count;
  logic [word_size-1:0] sel_word;
  logic                 sel_valid;
  logic                 xfer;
  logic                 stall_hit;
  logic [len_width-1:0] header;

  always_comb begin
    sel_word  = active_src ? req_word[word_size +: word_size] : req_word[word_size-1:0];
    sel_valid = req_valid[active_src];
    req_ready = 2'b00;
    if (state == LEN_LO || state == LEN_HI) begin
      req_ready[active_src] = 1'b1;
    end else if (state == STREAM) begin
      req_ready[active_src] = dec_ready;
    end
    xfer   = sel_valid && req_ready[active_src];
    header = len_width'({sel_word, len_lo});
  end

`ifdef LZ4_SCHED_TIMEOUT_EN
  localparam int stall_w = $clog2(timeout_cycles + 1);

  logic [stall_w-1:0] stall_cnt;
  logic               in_block;

  // Only a silent requester counts; decompressor back-pressure is not its fault.
  assign in_block  = (state == LEN_LO) || (state == LEN_HI) || (state == STREAM);
  assign stall_hit = in_block && !sel_valid && (stall_cnt == stall_w'(timeout_cycles - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (!in_block || xfer) begin
      stall_cnt <= '0;
    end else if (!sel_valid) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (timeout_cycles != 0);
  assign stall_hit          = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      ptr             <= 1'b0;
      active_src      <= 1'b0;
      busy            <= 1'b0;
      len_lo          <= '0;
      count           <= '0;
      compressed_word <= '0;
      write           <= 1'b0;
      block_done      <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      write       <= 1'b0;
      block_done  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            active_src <= req_valid[ptr] ? ptr : ~ptr;
            busy       <= 1'b1;
            state      <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len_lo <= sel_word;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            if (header == '0) begin
              busy       <= 1'b0;
              block_done <= 1'b1;
              state      <= DONE;
            end else begin
              count <= header;
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (xfer) begin
            compressed_word <= sel_word;
            write           <= 1'b1;
            count           <= count - 1'b1;
            if (count == len_width'(1)) begin
              busy       <= 1'b0;
              block_done <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          ptr   <= ~active_src;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Watchdog abort drops the rest of the block and hands the grant on.
      if (stall_hit) begin
        busy        <= 1'b0;
        block_done  <= 1'b1;
        timeout_err <= 1'b1;
        state       <= DONE;
      end
    end
  end

endmodule
